mealy_tracker: RTL and testbench

MEALY_TRACKER -- requirements
Module: mealy_tracker

---
 rtl/mealy_pkg.sv | 35 +++
 rtl/mealy_tracker_if.sv | 25 ++
 rtl/mealy_out_lut.sv | 21 ++
 rtl/mealy_tracker.sv | 93 +++++++++
 tb/tb_mealy_tracker.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mealy_pkg.sv
// Shared types and constants for the Mealy-machine input tracker.
// Holds the state encoding, the forward code table constants and the error counter width.
package mealy_pkg;

  typedef enum logic [1:0] {
    ST_A = 2'b00,
    ST_B = 2'b01,
    ST_C = 2'b10,
    ST_D = 2'b11
  } state_t;

  localparam logic [2:0] CODE_A0 = 3'b111;
  localparam logic [2:0] CODE_A1 = 3'b101;
  localparam logic [2:0] CODE_B0 = 3'b001;
  localparam logic [2:0] CODE_B1 = 3'b011;
  localparam logic [2:0] CODE_C0 = 3'b000;
  localparam logic [2:0] CODE_C1 = 3'b100;
  localparam logic [2:0] CODE_D  = 3'b110;

  localparam int ERR_CNT_W = 8;

  // Remote machine transition: D always returns to A regardless of input.
  function automatic state_t next_state(input state_t s, input logic in_bit);
    state_t ns;
    ns = ST_A;
    case (s)
      ST_A: ns = in_bit ? ST_B : ST_A;
      ST_B: ns = in_bit ? ST_B : ST_C;
      ST_C: ns = in_bit ? ST_D : ST_A;
      default: ns = ST_A;
    endcase
    return ns;
  endfunction

endpackage

// File: rtl/mealy_tracker_if.sv
// Code-observation bus: observed codes in, recovered inputs / tracked state / errors out.
// No backpressure; the tracker accepts a code every cycle.
interface mealy_tracker_if;
  import mealy_pkg::*;

  logic                 code_valid;
  logic [2:0]           code;
  logic                 in_valid;
  logic                 in_bit;
  logic                 in_amb;
  logic [1:0]           state;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output code_valid, code,
    input  in_valid, in_bit, in_amb, state, err, err_cnt
  );

  modport slave (
    input  code_valid, code,
    output in_valid, in_bit, in_amb, state, err, err_cnt
  );

endinterface

// File: rtl/mealy_out_lut.sv
// Forward output table of the remote machine: (state, input) -> 3-bit code.
// Purely combinational, zero latency, no backpressure.
module mealy_out_lut
  import mealy_pkg::*;
(
  input  state_t     st,
  input  logic       in_bit,
  output logic [2:0] code
);

  always_comb begin
    code = CODE_D;
    case (st)
      ST_A: code = in_bit ? CODE_A1 : CODE_A0;
      ST_B: code = in_bit ? CODE_B1 : CODE_B0;
      ST_C: code = in_bit ? CODE_C1 : CODE_C0;
      default: code = CODE_D;
    endcase
  end

endmodule

// File: rtl/mealy_tracker.sv
// Tracks a remote Mealy machine from its observed output codes and recovers its input bits.
// All outputs registered, one cycle after the code; accepts a code every cycle, no backpressure.
module mealy_tracker
  import mealy_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  mealy_tracker_if.slave  bus
);

  logic [2:0] cand0;
  logic [2:0] cand1;
  logic       match0;
  logic       match1;

  state_t               state_q, state_d;
  logic                 in_valid_q, in_valid_d;
  logic                 in_bit_q, in_bit_d;
  logic                 in_amb_q, in_amb_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  mealy_out_lut u_lut0 (
    .st     (state_q),
    .in_bit (1'b0),
    .code   (cand0)
  );

  mealy_out_lut u_lut1 (
    .st     (state_q),
    .in_bit (1'b1),
    .code   (cand1)
  );

  assign match0 = (bus.code == cand0);
  assign match1 = (bus.code == cand1);

  always_comb begin
    state_d    = state_q;
    in_valid_d = 1'b0;
    in_bit_d   = 1'b0;
    in_amb_d   = 1'b0;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    if (bus.code_valid) begin
      if (match0 && match1) begin
        // Both inputs produce the same code: report 0 but flag it.
        in_valid_d = 1'b1;
        in_amb_d   = 1'b1;
        state_d    = next_state(state_q, 1'b0);
      end else if (match0) begin
        in_valid_d = 1'b1;
        state_d    = next_state(state_q, 1'b0);
      end else if (match1) begin
        in_valid_d = 1'b1;
        in_bit_d   = 1'b1;
        state_d    = next_state(state_q, 1'b1);
      end else begin
        err_d   = 1'b1;
        state_d = ST_A;
        if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_A;
      in_valid_q <= 1'b0;
      in_bit_q   <= 1'b0;
      in_amb_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_valid_q <= in_valid_d;
      in_bit_q   <= in_bit_d;
      in_amb_q   <= in_amb_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.in_valid = in_valid_q;
  assign bus.in_bit   = in_bit_q;
  assign bus.in_amb   = in_amb_q;
  assign bus.state    = state_q;
  assign bus.err      = err_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_mealy_tracker.sv
// Directed bench for mealy_tracker: table-driven reference model checked every cycle,
// plus literal expectations on the named scenarios.
module tb_mealy_tracker;

  logic clk;
  logic reset;

  mealy_tracker_if bus ();

  mealy_tracker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Reference tables indexed [state][input]; states A=0 B=1 C=2 D=3.
  int out_tab [4][2] = '{'{7, 5}, '{1, 3}, '{0, 4}, '{6, 6}};
  int nxt_tab [4][2] = '{'{0, 1}, '{2, 1}, '{0, 3}, '{0, 0}};

  int m_state = 0;
  int m_cnt   = 0;
  int e_iv    = 0;
  int e_bit   = 0;
  int e_amb   = 0;
  int e_err   = 0;

  always @(posedge clk) begin
    int hits;
    int first;
    if (reset) begin
      m_state = 0; m_cnt = 0;
      e_iv = 0; e_bit = 0; e_amb = 0; e_err = 0;
    end else begin
      e_iv = 0; e_bit = 0; e_amb = 0; e_err = 0;
      if (bus.code_valid) begin
        hits  = 0;
        first = -1;
        for (int i = 0; i < 2; i++) begin
          if (out_tab[m_state][i] == int'(bus.code)) begin
            hits++;
            if (first < 0) first = i;
          end
        end
        if (hits == 0) begin
          e_err   = 1;
          m_state = 0;
          m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
        end else begin
          e_iv    = 1;
          e_bit   = first;
          e_amb   = (hits == 2) ? 1 : 0;
          m_state = nxt_tab[m_state][first];
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model.in_valid", int'(bus.in_valid), e_iv);
      chk("model.in_bit",   int'(bus.in_bit),   e_bit);
      chk("model.in_amb",   int'(bus.in_amb),   e_amb);
      chk("model.err",      int'(bus.err),      e_err);
      chk("model.state",    int'(bus.state),    m_state);
      chk("model.err_cnt",  int'(bus.err_cnt),  m_cnt);
      chk("model.exclusive", int'(bus.in_valid && bus.err), 0);
    end
  end

  task automatic step(input logic r, input logic v, input logic [2:0] c);
    reset          = r;
    bus.code_valid = v;
    bus.code       = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    bus.code_valid = 1'b0;
    bus.code       = 3'b000;
    step(1'b1, 1'b0, 3'b000);
    step(1'b1, 1'b1, 3'b101);
    chk_en = 1'b1;
    chk("reset.state",    int'(bus.state),    0);
    chk("reset.in_valid", int'(bus.in_valid), 0);
    chk("reset.err",      int'(bus.err),      0);
    chk("reset.err_cnt",  int'(bus.err_cnt),  0);

    // Basic decode A->B->B->C->A
    step(1'b0, 1'b1, 3'b101);
    chk("seq1.iv", int'(bus.in_valid), 1); chk("seq1.bit", int'(bus.in_bit), 1); chk("seq1.state", int'(bus.state), 1);
    step(1'b0, 1'b1, 3'b011);
    chk("seq2.bit", int'(bus.in_bit), 1); chk("seq2.state", int'(bus.state), 1);
    step(1'b0, 1'b1, 3'b001);
    chk("seq3.bit", int'(bus.in_bit), 0); chk("seq3.state", int'(bus.state), 2);
    step(1'b0, 1'b1, 3'b000);
    chk("seq4.iv", int'(bus.in_valid), 1); chk("seq4.bit", int'(bus.in_bit), 0); chk("seq4.state", int'(bus.state), 0);

    // C -> D -> A with ambiguous code
    step(1'b0, 1'b1, 3'b101);
    step(1'b0, 1'b1, 3'b001);
    step(1'b0, 1'b1, 3'b100);
    chk("cd.bit", int'(bus.in_bit), 1); chk("cd.state", int'(bus.state), 3);
    step(1'b0, 1'b1, 3'b110);
    chk("amb.iv", int'(bus.in_valid), 1); chk("amb.amb", int'(bus.in_amb), 1);
    chk("amb.bit", int'(bus.in_bit), 0); chk("amb.state", int'(bus.state), 0);

    // Illegal code in A
    step(1'b0, 1'b1, 3'b000);
    chk("ill.err", int'(bus.err), 1); chk("ill.iv", int'(bus.in_valid), 0);
    chk("ill.state", int'(bus.state), 0); chk("ill.cnt", int'(bus.err_cnt), 1);

    // Illegal code in D resyncs to A
    step(1'b0, 1'b1, 3'b101);
    step(1'b0, 1'b1, 3'b001);
    step(1'b0, 1'b1, 3'b100);
    step(1'b0, 1'b1, 3'b111);
    chk("illD.err", int'(bus.err), 1); chk("illD.state", int'(bus.state), 0); chk("illD.cnt", int'(bus.err_cnt), 2);

    // Saturation
    for (int i = 0; i < 260; i++) begin
      step(1'b0, 1'b1, 3'b000);
      chk("sat.err", int'(bus.err), 1);
    end
    chk("sat.cnt", int'(bus.err_cnt), 255);

    // Idle cycle holds, garbage code ignored
    step(1'b0, 1'b0, 3'b010);
    chk("idle.err", int'(bus.err), 0); chk("idle.cnt", int'(bus.err_cnt), 255);

    // Reset beats a valid code in state B
    step(1'b0, 1'b1, 3'b101);
    chk("preRst.state", int'(bus.state), 1);
    step(1'b1, 1'b1, 3'b101);
    chk("rst.state", int'(bus.state), 0); chk("rst.iv", int'(bus.in_valid), 0); chk("rst.cnt", int'(bus.err_cnt), 0);
    step(1'b0, 1'b1, 3'b101);
    chk("resume.state", int'(bus.state), 1); chk("resume.bit", int'(bus.in_bit), 1);
    step(1'b0, 1'b1, 3'b001);
    step(1'b0, 1'b1, 3'b000);

    // Gapped sequence
    step(1'b0, 1'b1, 3'b101);
    chk("gap1.bit", int'(bus.in_bit), 1);
    step(1'b0, 1'b0, 3'b111);
    chk("gapA.iv", int'(bus.in_valid), 0); chk("gapA.state", int'(bus.state), 1);
    step(1'b0, 1'b0, 3'b000);
    chk("gapB.err", int'(bus.err), 0); chk("gapB.state", int'(bus.state), 1);
    step(1'b0, 1'b1, 3'b011);
    chk("gap2.bit", int'(bus.in_bit), 1); chk("gap2.state", int'(bus.state), 1);
    step(1'b0, 1'b0, 3'b011);
    chk("gapC.iv", int'(bus.in_valid), 0);
    step(1'b0, 1'b1, 3'b001);
    chk("gap3.bit", int'(bus.in_bit), 0); chk("gap3.state", int'(bus.state), 2);
    step(1'b0, 1'b1, 3'b000);
    chk("gap4.iv", int'(bus.in_valid), 1); chk("gap4.state", int'(bus.state), 0);
    chk("gap.cnt", int'(bus.err_cnt), 0);

    step(1'b0, 1'b0, 3'b000);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
